// File: rtl/voice_oscillator_bank.sv
`default_nettype none
// ============================================================================
// Module   : voice_oscillator_bank
// Brief    : Fractional sample-tick generator driving VOICES time-multiplexed
//            phase-accumulator oscillators, mixed to one signed sample per tick.
//            Optional macro: VOICE_OSC_SATURATE_EN (clamp instead of wrap).
// Revision : 1.0
// ============================================================================
module voice_oscillator_bank #(
    parameter int CLOCK_HZ    = 50_000_000,
    parameter int SAMPLE_RATE = 44_100,
    parameter int VOICES      = 4,
    parameter int PHASE_WIDTH = 24,
    parameter int AUDIO_WIDTH = 16,
    parameter int MIX_SHIFT   = $clog2(VOICES)
) (
    input  logic                      clock_50_000_000,
    input  logic                      reset_l,
    input  logic                      voice_wr_en,
    input  logic [$clog2(VOICES)-1:0] voice_wr_idx,
    input  logic [PHASE_WIDTH-1:0]    voice_wr_inc,
    input  logic                      voice_wr_gate,
    input  logic [1:0]                waveform,
    output logic [AUDIO_WIDTH-1:0]    audio_out,
    output logic                      audio_valid,
    output logic                      overrun
);

    localparam int c_idx_w = $clog2(VOICES);
    localparam int c_sum_w = AUDIO_WIDTH + c_idx_w;
    localparam int c_acc_w = $clog2(CLOCK_HZ + SAMPLE_RATE + 1);
    localparam logic [c_acc_w-1:0] c_clock = c_acc_w'(CLOCK_HZ);
    localparam logic [c_acc_w-1:0] c_rate  = c_acc_w'(SAMPLE_RATE);
    localparam logic [AUDIO_WIDTH-1:0] c_half = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
    localparam logic signed [c_sum_w-1:0] c_sat_hi = c_sum_w'(2 ** (AUDIO_WIDTH - 1) - 1);
    localparam logic signed [c_sum_w-1:0] c_sat_lo = ~c_sat_hi;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [c_acc_w-1:0]        tick_acc_q, tick_acc_d, tick_sum;
    logic                      tick;
    logic                      pending_q, pending_d;
    logic                      overrun_q, overrun_d;
    logic [1:0]                wave_q, wave_d;
    logic [c_idx_w-1:0]        v_q, v_d;
    logic signed [c_sum_w-1:0] sum_q, sum_d, sum_next, shifted;
    logic [AUDIO_WIDTH-1:0]    contrib;
    logic [AUDIO_WIDTH-1:0]    mix_val;
    logic [AUDIO_WIDTH-1:0]    audio_out_q, audio_out_d;
    logic                      audio_valid_q, audio_valid_d;
    logic [PHASE_WIDTH-1:0]    phase_q [VOICES];
    logic [PHASE_WIDTH-1:0]    phase_d [VOICES];
    logic [PHASE_WIDTH-1:0]    inc_q   [VOICES];
    logic [PHASE_WIDTH-1:0]    inc_d   [VOICES];
    logic [VOICES-1:0]         gate_q, gate_d;

    // p is the top AUDIO_WIDTH bits of the phase, treated as unsigned.
    function automatic logic [AUDIO_WIDTH-1:0] wave_sample(
        input logic [AUDIO_WIDTH-1:0] p,
        input logic [1:0]             sel
    );
        logic [AUDIO_WIDTH-1:0] fold;
        fold = p[AUDIO_WIDTH-1] ? ~p : p;
        case (sel)
            2'b00:   wave_sample = p - c_half;
            2'b01:   wave_sample = p[AUDIO_WIDTH-1] ? c_half : ~c_half;
            2'b10:   wave_sample = (fold << 1) - c_half;
            default: wave_sample = '0;
        endcase
    endfunction

    always_comb begin
        tick_sum      = tick_acc_q + c_rate;
        tick          = (tick_sum >= c_clock);
        tick_acc_d    = tick ? (tick_sum - c_clock) : tick_sum;
        overrun_d     = overrun_q | (tick & pending_q);
        pending_d     = pending_q;
        state_d       = state_q;
        wave_d        = wave_q;
        v_d           = v_q;
        sum_d         = sum_q;
        audio_out_d   = audio_out_q;
        audio_valid_d = 1'b0;

        contrib  = gate_q[v_q] ? wave_sample(phase_q[v_q][PHASE_WIDTH-1 -: AUDIO_WIDTH], wave_q) : '0;
        sum_next = sum_q + {{c_idx_w{contrib[AUDIO_WIDTH-1]}}, contrib};
        shifted  = sum_next >>> MIX_SHIFT;
`ifdef VOICE_OSC_SATURATE_EN
        if (shifted > c_sat_hi) begin
            mix_val = c_sat_hi[AUDIO_WIDTH-1:0];
        end else if (shifted < c_sat_lo) begin
            mix_val = c_sat_lo[AUDIO_WIDTH-1:0];
        end else begin
            mix_val = shifted[AUDIO_WIDTH-1:0];
        end
`else
        mix_val = shifted[AUDIO_WIDTH-1:0];
`endif

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_ACCUM;
                    pending_d = 1'b0;
                    wave_d    = waveform;
                    sum_d     = '0;
                    v_d       = '0;
                end
            end
            S_ACCUM: begin
                sum_d = sum_next;
                v_d   = v_q + c_idx_w'(1);
                // The output register loads with the last voice so valid and data leave together.
                if (v_q == c_idx_w'(VOICES - 1)) begin
                    state_d       = S_OUTPUT;
                    audio_out_d   = mix_val;
                    audio_valid_d = 1'b1;
                end
            end
            S_OUTPUT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (tick) begin
            pending_d = 1'b1;
        end
    end

    // Host writes override the accumulator advance, so the stored values follow the write.
    always_comb begin
        gate_d = gate_q;
        for (int i = 0; i < VOICES; i++) begin
            phase_d[i] = phase_q[i];
            inc_d[i]   = inc_q[i];
            if ((state_q == S_ACCUM) && (v_q == c_idx_w'(i)) && gate_q[i]) begin
                phase_d[i] = phase_q[i] + inc_q[i];
            end
            if (voice_wr_en && (voice_wr_idx == c_idx_w'(i))) begin
                inc_d[i]  = voice_wr_inc;
                gate_d[i] = voice_wr_gate;
                if (voice_wr_gate && !gate_q[i]) begin
                    phase_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) begin
            state_q       <= S_IDLE;
            tick_acc_q    <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            wave_q        <= 2'b00;
            v_q           <= '0;
            sum_q         <= '0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
            gate_q        <= '0;
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            tick_acc_q    <= tick_acc_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            wave_q        <= wave_d;
            v_q           <= v_d;
            sum_q         <= sum_d;
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
            gate_q        <= gate_d;
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= phase_d[i];
                inc_q[i]   <= inc_d[i];
            end
        end
    end

    assign audio_out   = audio_out_q;
    assign audio_valid = audio_valid_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_oscillator_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_oscillator_bank
// Brief    : Directed bench for voice_oscillator_bank: tick timing, waveforms,
//            mixing, retrigger, write collision, mid-sample reset and overrun.
// Revision : 1.0
// ============================================================================
module tb_voice_oscillator_bank;

    logic        clk = 1'b0;
    logic        rst_l, ov_rst_l;
    logic        wr_en, wr_gate;
    logic [1:0]  wr_idx, wave;
    logic [23:0] wr_inc;
    logic [15:0] aout;
    logic        avalid, aovr;
    logic        mx_wr_en, mx_wr_gate;
    logic [1:0]  mx_wr_idx, mx_wave;
    logic [23:0] mx_wr_inc;
    logic [15:0] mx_out;
    logic        mx_valid, mx_ovr;
    logic [15:0] ov_out;
    logic        ov_valid, ov_ovr;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;
    int rel   = 0;
    int pulse_idx = 0;

`ifdef VOICE_OSC_SATURATE_EN
    localparam logic [15:0] c_mix_exp = 16'h7FFF;
`else
    localparam logic [15:0] c_mix_exp = 16'hFFFC;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    voice_oscillator_bank dut (
        .clock_50_000_000(clk), .reset_l(rst_l),
        .voice_wr_en(wr_en), .voice_wr_idx(wr_idx), .voice_wr_inc(wr_inc),
        .voice_wr_gate(wr_gate), .waveform(wave),
        .audio_out(aout), .audio_valid(avalid), .overrun(aovr)
    );

    voice_oscillator_bank #(.MIX_SHIFT(0)) dut_mix (
        .clock_50_000_000(clk), .reset_l(rst_l),
        .voice_wr_en(mx_wr_en), .voice_wr_idx(mx_wr_idx), .voice_wr_inc(mx_wr_inc),
        .voice_wr_gate(mx_wr_gate), .waveform(mx_wave),
        .audio_out(mx_out), .audio_valid(mx_valid), .overrun(mx_ovr)
    );

    voice_oscillator_bank #(.CLOCK_HZ(8), .SAMPLE_RATE(2), .VOICES(4)) dut_ov (
        .clock_50_000_000(clk), .reset_l(ov_rst_l),
        .voice_wr_en(1'b0), .voice_wr_idx(2'd0), .voice_wr_inc(24'd0),
        .voice_wr_gate(1'b0), .waveform(2'b00),
        .audio_out(ov_out), .audio_valid(ov_valid), .overrun(ov_ovr)
    );

    // Edge (counted from reset release) of the k-th tick: ceil(k * 50e6 / 44100).
    function automatic int tick_edge(input int k);
        longint t;
        t = (longint'(k) * 64'd50000000 + 64'd44099) / 64'd44100;
        return int'(t);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output logic [15:0] smp, output int at_edge);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (avalid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("valid_seen", {31'd0, got}, 32'd1);
        pulse_idx++;
        smp     = aout;
        at_edge = edges;
    endtask

    task automatic vwrite(input logic [1:0] idx, input logic [23:0] inc, input logic gate);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_inc  = inc;
        wr_gate = gate;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Leaves the caller at the negedge where ACCUM is processing voice v of the next sample.
    task automatic wait_accum_voice(input int v);
        int target;
        bit hit;
        target = rel + tick_edge(pulse_idx + 1) + 1 + v;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (edges == target) begin
                hit = 1'b1;
                break;
            end
        end
        check("accum_slot_reached", {31'd0, hit}, 32'd1);
    endtask

    initial begin
        logic [15:0] smp;
        int          at, prev_at, first_at;
        int          seen;
        logic [15:0] saw_exp [5];
        logic [15:0] tri_exp [4];
        logic [15:0] col_exp [4];

        saw_exp = '{16'hE000, 16'hE400, 16'hE800, 16'hEC00, 16'hF000};
        tri_exp = '{16'hE000, 16'h0000, 16'h1FFF, 16'hFFFF};
        col_exp = '{16'hE000, 16'hE400, 16'hE800, 16'hF800};

        rst_l = 1'b0; ov_rst_l = 1'b0;
        wr_en = 1'b0; wr_idx = 2'd0; wr_inc = 24'd0; wr_gate = 1'b0; wave = 2'b00;
        mx_wr_en = 1'b0; mx_wr_idx = 2'd0; mx_wr_inc = 24'd0; mx_wr_gate = 1'b0; mx_wave = 2'b01;
        repeat (3) @(negedge clk);
        check("reset_audio_out", {16'd0, aout}, 32'd0);
        check("reset_audio_valid", {31'd0, avalid}, 32'd0);
        check("reset_overrun", {31'd0, aovr}, 32'd0);
        check("reset_ov_overrun", {31'd0, ov_ovr}, 32'd0);

        rst_l = 1'b1;
        rel   = edges;
        for (int v = 0; v < 4; v++) begin
            mx_wr_en = 1'b1; mx_wr_idx = 2'(v); mx_wr_inc = 24'd0; mx_wr_gate = 1'b1;
            @(negedge clk);
        end
        mx_wr_en = 1'b0;

        // Tick timing: first pulse, then 20 exact intervals and the overall span.
        wait_valid(1300, smp, at);
        first_at = at;
        check("first_valid_edge", 32'(at - rel), 32'(tick_edge(1) + 5));
        check("idle_sample", {16'd0, smp}, 32'd0);
        check("mix_valid", {31'd0, mx_valid}, 32'd1);
        check("mix_square_4v", {16'd0, mx_out}, {16'd0, c_mix_exp});
        prev_at = at;
        for (int k = 2; k <= 21; k++) begin
            wait_valid(1300, smp, at);
            check("tick_interval", 32'(at - prev_at), 32'(tick_edge(k) - tick_edge(k - 1)));
            prev_at = at;
        end
        check("tick_span_20", 32'(prev_at - first_at), 32'd22676);
        check("no_overrun", {31'd0, aovr}, 32'd0);

        // Saw on voice 0.
        wave = 2'b00;
        vwrite(2'd0, 24'h100000, 1'b1);
        for (int s = 0; s < 5; s++) begin
            wait_valid(1300, smp, at);
            check("saw_sample", {16'd0, smp}, {16'd0, saw_exp[s]});
        end

        // Note off then retrigger.
        vwrite(2'd0, 24'h100000, 1'b0);
        wait_valid(1300, smp, at);
        check("gate_off_sample", {16'd0, smp}, 32'd0);
        vwrite(2'd0, 24'h100000, 1'b1);
        wait_valid(1300, smp, at);
        check("retrigger_sample", {16'd0, smp}, 32'h0000E000);

        // Triangle, quarter-cycle steps from a fresh phase.
        vwrite(2'd0, 24'h100000, 1'b0);
        wave = 2'b10;
        vwrite(2'd0, 24'h400000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            wait_valid(1300, smp, at);
            check("tri_sample", {16'd0, smp}, {16'd0, tri_exp[s]});
        end

        // Four gated squares at phase 0, default shift.
        wave = 2'b01;
        vwrite(2'd0, 24'd0, 1'b0);
        for (int v = 0; v < 4; v++) vwrite(2'(v), 24'd0, 1'b1);
        wait_valid(1300, smp, at);
        check("square_4v_shift2", {16'd0, smp}, 32'h00007FFF);

        wave = 2'b11;
        wait_valid(1300, smp, at);
        check("silence", {16'd0, smp}, 32'd0);

        // Collision: voice 1 inc rewritten while ACCUM is on voice 1.
        wave = 2'b00;
        vwrite(2'd0, 24'd0, 1'b0);
        vwrite(2'd2, 24'd0, 1'b0);
        vwrite(2'd3, 24'd0, 1'b0);
        vwrite(2'd1, 24'h100000, 1'b1);
        wait_valid(1300, smp, at);
        check("col_sample_a", {16'd0, smp}, {16'd0, col_exp[0]});
        wait_accum_voice(1);
        vwrite(2'd1, 24'h400000, 1'b1);
        for (int s = 1; s < 4; s++) begin
            wait_valid(1300, smp, at);
            check("col_sample", {16'd0, smp}, {16'd0, col_exp[s]});
        end

        // Reset in the middle of ACCUM discards the sample.
        wait_accum_voice(2);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (avalid === 1'b1) seen++;
        end
        check("reset_mid_no_valid", 32'(seen), 32'd0);
        check("reset_mid_audio_out", {16'd0, aout}, 32'd0);
        check("reset_mid_overrun", {31'd0, aovr}, 32'd0);

        // Overrun on a too-fast tick rate; sticky until reset.
        ov_rst_l = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov_ovr === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("overrun_raised", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        check("overrun_sticky", {31'd0, ov_ovr}, 32'd1);
        ov_rst_l = 1'b0;
        @(negedge clk);
        ov_rst_l = 1'b1;
        check("overrun_cleared", {31'd0, ov_ovr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
